cam_lane_align: RTL and testbench

CAM_LANE_ALIGN -- requirements
Module: cam_lane_align

---
 rtl/cam_lane_align.sv | 256 +++++++++++++++++++++++++
 tb/tb_cam_lane_align.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_lane_align.sv
// cam_lane_align -- word aligner for a 4-data + 1-sync lane camera deserializer.
// Each lane is trained to the TRAIN word using one-hot bitslip pulses. Once all
// five lanes are aligned, the sync lane is decoded into px_valid and
// frame/line-start markers.
// Optional feature: define CAM_ALIGN_STATS_EN to build the frame and
// realignment counters; otherwise frame_cnt/realign_cnt are tied to 0.
// SLIP_WAIT and MATCH_N are expected to be at least 1.
module cam_lane_align #(
   parameter logic [7:0] TRAIN     = 8'h3A,
   parameter logic [7:0] SYNC_FS   = 8'hAA,
   parameter logic [7:0] SYNC_LS   = 8'h2A,
   parameter logic [7:0] SYNC_DV   = 8'h0D,
   parameter int         SLIP_WAIT = 4,
   parameter int         MATCH_N   = 4
) (
   input  logic        c,
   input  logic        rst,
   input  logic [39:0] rxd,
   input  logic        rx_locked,
   input  logic        realign,
   output logic [4:0]  bitslip,
   output logic        aligned,
   output logic        align_err,
   output logic [31:0] px_data,
   output logic        px_valid,
   output logic        frame_start,
   output logic        line_start,
   output logic [15:0] frame_cnt,
   output logic [7:0]  realign_cnt
);

   typedef enum logic [2:0] {WAIT_LOCK, CHECK, SLIP, SETTLE, NEXT, RUN} state_t;

   localparam int MATCH_W  = (MATCH_N > 1) ? $clog2(MATCH_N) : 1;
   localparam int SETTLE_W = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;
   localparam logic [MATCH_W-1:0]  MATCH_LAST  = MATCH_W'(MATCH_N - 1);
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SLIP_WAIT - 1);
   localparam logic [2:0]          LAST_LANE   = 3'd4;

   state_t              state_q, state_d;
   logic [2:0]          lane_q, lane_d;
   logic [2:0]          slip_q, slip_d;
   logic [MATCH_W-1:0]  match_q, match_d;
   logic [SETTLE_W-1:0] settle_q, settle_d;
   logic [3:0]          lock_cnt_q, lock_cnt_d;
   logic                lock_meta_q, lock_sync_q;
   logic                align_err_q, align_err_d;
   logic                px_valid_q, px_valid_d;
   logic [31:0]         px_data_q, px_data_d;
   logic                frame_start_q, frame_start_d;
   logic                line_start_q, line_start_d;
   logic                fs_arm_q, fs_arm_d;
   logic                ls_arm_q, ls_arm_d;
   logic [7:0]          lane_word;
   logic [7:0]          sync_word;

   assign sync_word = rxd[39:32];

   // Two-flop synchronizer: rx_locked comes from the PLL, asynchronous to c.
   always_ff @(posedge c or posedge rst) begin
      if (rst) begin
         lock_meta_q <= 1'b0;
         lock_sync_q <= 1'b0;
      end else begin
         lock_meta_q <= rx_locked;
         lock_sync_q <= lock_meta_q;
      end
   end

   // Select the word of the lane currently being trained.
   always_comb begin
      lane_word = rxd[7:0];
      case (lane_q)
         3'd1:    lane_word = rxd[15:8];
         3'd2:    lane_word = rxd[23:16];
         3'd3:    lane_word = rxd[31:24];
         3'd4:    lane_word = rxd[39:32];
         default: lane_word = rxd[7:0];
      endcase
   end

   // Alignment FSM next state plus sync-lane decode while running.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
      state_d       = state_q;
      lane_d        = lane_q;
      slip_d        = slip_q;
      match_d       = match_q;
      settle_d      = settle_q;
      lock_cnt_d    = lock_cnt_q;
      align_err_d   = align_err_q;
      px_valid_d    = 1'b0;
      px_data_d     = px_data_q;
      frame_start_d = 1'b0;
      line_start_d  = 1'b0;
      fs_arm_d      = fs_arm_q;
      ls_arm_d      = ls_arm_q;

      if (realign || !lock_sync_q) begin
         // Realign request or lost lock: start over and drop any pending markers.
         state_d    = WAIT_LOCK;
         lock_cnt_d = '0;
         fs_arm_d   = 1'b0;
         ls_arm_d   = 1'b0;
      end else begin
         case (state_q)
            WAIT_LOCK: begin
               if (lock_cnt_q == 4'd15) begin
                  state_d = CHECK;
                  lane_d  = '0;
                  slip_d  = '0;
                  match_d = '0;
               end else begin
                  lock_cnt_d = lock_cnt_q + 4'd1;
               end
            end
            CHECK: begin
               if (lane_word == TRAIN) begin
                  if (match_q == MATCH_LAST) state_d = NEXT;
                  else match_d = match_q + 1'b1;
               end else begin
                  state_d = SLIP;
               end
            end
            SLIP: begin
               if (slip_q == 3'd7) begin
                  // Eighth slip wraps the lane back to where it started:
                  // flag the failure and retrain from lane 0 without a lock wait.
                  align_err_d = 1'b1;
                  state_d     = CHECK;
                  lane_d      = '0;
                  slip_d      = '0;
                  match_d     = '0;
               end else begin
                  slip_d   = slip_q + 3'd1;
                  settle_d = '0;
                  state_d  = SETTLE;
               end
            end
            SETTLE: begin
               if (settle_q == SETTLE_LAST) begin
                  state_d = CHECK;
                  match_d = '0;
               end else begin
                  settle_d = settle_q + 1'b1;
               end
            end
            NEXT: begin
               if (lane_q == LAST_LANE) begin
                  state_d     = RUN;
                  align_err_d = 1'b0;
               end else begin
                  lane_d  = lane_q + 3'd1;
                  slip_d  = '0;
                  match_d = '0;
                  state_d = CHECK;
               end
            end
            RUN: begin
               if (sync_word == SYNC_DV) begin
                  px_valid_d    = 1'b1;
                  px_data_d     = rxd[31:0];
                  frame_start_d = fs_arm_q;
                  line_start_d  = ls_arm_q;
                  fs_arm_d      = 1'b0;
                  ls_arm_d      = 1'b0;
               end else if (sync_word == SYNC_FS) begin
                  fs_arm_d = 1'b1;
                  ls_arm_d = 1'b1;
               end else if (sync_word == SYNC_LS) begin
                  ls_arm_d = 1'b1;
               end
            end
            default: state_d = WAIT_LOCK;
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge c or posedge rst) begin
      if (rst) begin
         state_q       <= WAIT_LOCK;
         lane_q        <= '0;
         slip_q        <= '0;
         match_q       <= '0;
         settle_q      <= '0;
         lock_cnt_q    <= '0;
         align_err_q   <= 1'b0;
         px_valid_q    <= 1'b0;
         px_data_q     <= '0;
         frame_start_q <= 1'b0;
         line_start_q  <= 1'b0;
         fs_arm_q      <= 1'b0;
         ls_arm_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values and updates together.
         state_q       <= state_d;
         lane_q        <= lane_d;
         slip_q        <= slip_d;
         match_q       <= match_d;
         settle_q      <= settle_d;
         lock_cnt_q    <= lock_cnt_d;
         align_err_q   <= align_err_d;
         px_valid_q    <= px_valid_d;
         px_data_q     <= px_data_d;
         frame_start_q <= frame_start_d;
         line_start_q  <= line_start_d;
         fs_arm_q      <= fs_arm_d;
         ls_arm_q      <= ls_arm_d;
      end
   end

   // Bitslip is decoded from the async-reset state register, so rst kills a pulse at once.
   always_comb begin
      bitslip = '0;
      if (state_q == SLIP) bitslip[lane_q] = 1'b1;
   end

   assign aligned     = (state_q == RUN);
   assign align_err   = align_err_q;
   assign px_valid    = px_valid_q;
   assign px_data     = px_data_q;
   assign frame_start = frame_start_q;
   assign line_start  = line_start_q;

`ifdef CAM_ALIGN_STATS_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic [7:0]  realign_cnt_q, realign_cnt_d;

   // Frame count wraps; realign count saturates and counts exits from RUN.
   always_comb begin
      frame_cnt_d   = frame_cnt_q + {15'd0, frame_start_d};
      realign_cnt_d = realign_cnt_q;
      if (state_q == RUN && state_d == WAIT_LOCK && realign_cnt_q != 8'hFF)
         realign_cnt_d = realign_cnt_q + 8'd1;
   end

   // Statistics registers.
   always_ff @(posedge c or posedge rst) begin
      if (rst) begin
         frame_cnt_q   <= '0;
         realign_cnt_q <= '0;
      end else begin
         frame_cnt_q   <= frame_cnt_d;
         realign_cnt_q <= realign_cnt_d;
      end
   end

   assign frame_cnt   = frame_cnt_q;
   assign realign_cnt = realign_cnt_q;
`else
   assign frame_cnt   = '0;
   assign realign_cnt = '0;
`endif

endmodule

// File: tb/tb_cam_lane_align.sv
// Testbench for cam_lane_align: a deserializer model with per-lane bit rotation
// that reacts to bitslip, directed alignment scenarios, and a randomized RUN
// phase checked cycle by cycle against a sync-lane decode model.
module tb_cam_lane_align;

   localparam logic [7:0] TRAIN     = 8'h3A;
   localparam logic [7:0] SYNC_FS   = 8'hAA;
   localparam logic [7:0] SYNC_LS   = 8'h2A;
   localparam logic [7:0] SYNC_DV   = 8'h0D;
   localparam int         SLIP_WAIT = 4;
   localparam int         MATCH_N   = 4;
`ifdef CAM_ALIGN_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        c = 1'b0;
   logic        rst = 1'b1;
   logic [39:0] rxd;
   logic        rx_locked = 1'b0;
   logic        realign = 1'b0;
   logic [4:0]  bitslip;
   logic        aligned, align_err, px_valid, frame_start, line_start;
   logic [31:0] px_data;
   logic [15:0] frame_cnt;
   logic [7:0]  realign_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   // Deserializer model: each lane shows its source byte rotated left by skew;
   // every bitslip pulse on a lane removes one bit of skew.
   logic [7:0] src [5];
   int         skew [5];
   int         pulses [5];
   int         pulse_cyc [5][$];
   int         cyc_no = 0;
   logic [4:0] bs_prev = '0;

   always #5 c = ~c;

   cam_lane_align #(
      .TRAIN(TRAIN), .SYNC_FS(SYNC_FS), .SYNC_LS(SYNC_LS), .SYNC_DV(SYNC_DV),
      .SLIP_WAIT(SLIP_WAIT), .MATCH_N(MATCH_N)
   ) dut (
      .c(c), .rst(rst), .rxd(rxd), .rx_locked(rx_locked), .realign(realign),
      .bitslip(bitslip), .aligned(aligned), .align_err(align_err),
      .px_data(px_data), .px_valid(px_valid), .frame_start(frame_start),
      .line_start(line_start), .frame_cnt(frame_cnt), .realign_cnt(realign_cnt)
   );

   function automatic logic [7:0] rotl(input logic [7:0] w, input int s);
      logic [15:0] d;
      d = {w, w} << (s % 8);
      return d[15:8];
   endfunction

   assign rxd = {rotl(src[4], skew[4]), rotl(src[3], skew[3]), rotl(src[2], skew[2]),
                 rotl(src[1], skew[1]), rotl(src[0], skew[0])};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Bitslip monitor: one lane at a time, one-cycle pulses, silent in RUN/reset.
   always @(posedge c) begin
      #1;
      cyc_no++;
      check("bitslip_onehot", 64'($countones(bitslip) <= 1), 64'd1);
      check("bitslip_width", 64'(bitslip & bs_prev), 64'd0);
      if (aligned || rst) check("bitslip_idle", 64'(bitslip), 64'd0);
      for (int k = 0; k < 5; k++) begin
         if (bitslip[k]) begin
            pulses[k]++;
            pulse_cyc[k].push_back(cyc_no);
            skew[k] = (skew[k] + 7) % 8;
         end
      end
      bs_prev = bitslip;
   end

   // Sync-lane model: outputs after an edge follow the word seen at that edge,
   // provided the block was running before and after it.
   logic [7:0]  m_sync;
   logic [31:0] m_data;
   logic        m_prev_run = 1'b0;
   logic        m_fs_arm = 1'b0, m_ls_arm = 1'b0;
   logic        e_valid = 1'b0, e_fs = 1'b0, e_ls = 1'b0;
   logic [31:0] e_data = '0;
   logic [15:0] e_fcnt = '0;
   logic [7:0]  e_rcnt = '0;

   always @(posedge c) begin
      m_sync = rxd[39:32];
      m_data = rxd[31:0];
      #1;
      if (rst) begin
         e_valid = 1'b0; e_fs = 1'b0; e_ls = 1'b0;
         m_fs_arm = 1'b0; m_ls_arm = 1'b0;
         e_fcnt = '0; e_rcnt = '0;
         m_prev_run = 1'b0;
      end else if (m_prev_run && aligned) begin
         e_valid = (m_sync == SYNC_DV);
         e_fs = 1'b0;
         e_ls = 1'b0;
         if (m_sync == SYNC_DV) begin
            e_data = m_data;
            e_fs = m_fs_arm;
            e_ls = m_ls_arm;
            m_fs_arm = 1'b0;
            m_ls_arm = 1'b0;
         end else if (m_sync == SYNC_FS) begin
            m_fs_arm = 1'b1;
            m_ls_arm = 1'b1;
         end else if (m_sync == SYNC_LS) begin
            m_ls_arm = 1'b1;
         end
         if (STATS && e_fs) e_fcnt = e_fcnt + 16'd1;
      end else begin
         if (STATS && m_prev_run && e_rcnt != 8'hFF) e_rcnt = e_rcnt + 8'd1;
         e_valid = 1'b0; e_fs = 1'b0; e_ls = 1'b0;
         m_fs_arm = 1'b0; m_ls_arm = 1'b0;
      end
      check("px_valid", 64'(px_valid), 64'(e_valid));
      check("frame_start", 64'(frame_start), 64'(e_fs));
      check("line_start", 64'(line_start), 64'(e_ls));
      check("frame_cnt", 64'(frame_cnt), 64'(e_fcnt));
      check("realign_cnt", 64'(realign_cnt), 64'(e_rcnt));
      if (e_valid) check("px_data", 64'(px_data), 64'(e_data));
      if (!rst) m_prev_run = aligned;
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_bitslip"}, 64'(bitslip), 64'd0);
      check({tag, "_aligned"}, 64'(aligned), 64'd0);
      check({tag, "_align_err"}, 64'(align_err), 64'd0);
      check({tag, "_px_data"}, 64'(px_data), 64'd0);
      check({tag, "_px_valid"}, 64'(px_valid), 64'd0);
      check({tag, "_markers"}, 64'({frame_start, line_start}), 64'd0);
      check({tag, "_counters"}, 64'({frame_cnt, realign_cnt}), 64'd0);
   endtask

   task automatic do_reset();
      @(negedge c);
      rst = 1'b1;
      realign = 1'b0;
      rx_locked = 1'b1;
      for (int k = 0; k < 5; k++) begin
         src[k] = TRAIN;
         skew[k] = 0;
         pulses[k] = 0;
         pulse_cyc[k].delete();
      end
      repeat (2) @(negedge c);
      rst = 1'b0;
   endtask

   task automatic wait_aligned(input int limit, input string name);
      for (int i = 0; i < limit; i++) begin
         @(posedge c); #2;
         if (aligned) break;
      end
      check(name, 64'(aligned), 64'd1);
   endtask

   task automatic send(input logic [7:0] sync, input logic [31:0] data);
      @(negedge c);
      src[4] = sync;
      src[3] = data[31:24];
      src[2] = data[23:16];
      src[1] = data[15:8];
      src[0] = data[7:0];
      @(posedge c); #2;
   endtask

   task automatic run_random(input int n);
      int r;
      for (int i = 0; i < n; i++) begin
         @(negedge c);
         if (aligned) begin
            r = $urandom_range(0, 7);
            case (r)
               0, 1, 2: src[4] = SYNC_DV;
               3:       src[4] = SYNC_FS;
               4:       src[4] = SYNC_LS;
               5:       src[4] = TRAIN;
               default: src[4] = 8'($urandom);
            endcase
            for (int k = 0; k < 4; k++) src[k] = 8'($urandom);
            realign = ($urandom_range(0, 149) == 0);
         end else begin
            for (int k = 0; k < 5; k++) src[k] = TRAIN;
            realign = 1'b0;
         end
      end
      @(negedge c);
      realign = 1'b0;
   endtask

   initial begin
      int cyc;
      int n_lat;

      // Reset state.
      for (int k = 0; k < 5; k++) begin
         src[k] = TRAIN;
         skew[k] = 0;
      end
      rx_locked = 1'b1;
      repeat (2) @(negedge c);
      check_all_zero("reset");

      // Clean training: 2 sync + 16 lock + 5 lanes x (MATCH_N checks + 1 advance).
      do_reset();
      cyc = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge c); #2;
         cyc++;
         if (aligned) break;
      end
      check("t1_align_cycles", 64'(cyc), 64'(2 + 16 + 5 * (MATCH_N + 1)));
      check("t1_no_slips", 64'(pulses[0] + pulses[1] + pulses[2] + pulses[3] + pulses[4]), 64'd0);
      check("t1_no_err", 64'(align_err), 64'd0);

      // Sync-lane sequence FS, DV, DV, LS, TRAIN, DV, then FS, FS, DV, DV.
      send(SYNC_FS, $urandom);
      check("t2_fs_idle", 64'(px_valid), 64'd0);
      send(SYNC_DV, 32'h11223344);
      check("t2_dv1", 64'({px_valid, frame_start, line_start}), 64'b111);
      check("t2_dv1_data", 64'(px_data), 64'h11223344);
      check("t2_dv1_fcnt", 64'(frame_cnt), STATS ? 64'd1 : 64'd0);
      send(SYNC_DV, $urandom);
      check("t2_dv2", 64'({px_valid, frame_start, line_start}), 64'b100);
      send(SYNC_LS, $urandom);
      check("t2_ls_idle", 64'(px_valid), 64'd0);
      send(TRAIN, $urandom);
      check("t2_train_idle", 64'({px_valid, line_start}), 64'd0);
      send(SYNC_DV, $urandom);
      check("t2_dv3", 64'({px_valid, frame_start, line_start}), 64'b101);
      send(SYNC_FS, $urandom);
      send(SYNC_FS, $urandom);
      send(SYNC_DV, $urandom);
      check("t2_refs_dv", 64'({px_valid, frame_start, line_start}), 64'b111);
      send(SYNC_DV, $urandom);
      check("t2_refs_single", 64'({px_valid, frame_start, line_start}), 64'b100);
      check("t2_fcnt", 64'(frame_cnt), STATS ? 64'd2 : 64'd0);
      send(TRAIN, 32'h0);

      // Randomized RUN traffic with occasional realign requests.
      run_random(600);

      // Lane 2 skewed by 3 bits.
      do_reset();
      skew[2] = 3;
      wait_aligned(300, "t4_aligned");
      check("t4_slips_lane2", 64'(pulses[2]), 64'd3);
      check("t4_slips_other", 64'(pulses[0] + pulses[1] + pulses[3] + pulses[4]), 64'd0);
      if (pulse_cyc[2].size() >= 3) begin
         check("t4_gap1", 64'(pulse_cyc[2][1] - pulse_cyc[2][0]), 64'(1 + SLIP_WAIT + 1));
         check("t4_gap2", 64'(pulse_cyc[2][2] - pulse_cyc[2][1]), 64'(1 + SLIP_WAIT + 1));
      end

      // Lane 1 stuck at 0x00: eight slips, then error and restart.
      do_reset();
      src[1] = 8'h00;
      for (int i = 0; i < 300; i++) begin
         @(posedge c); #2;
         if (align_err) break;
      end
      check("t5_err_set", 64'(align_err), 64'd1);
      check("t5_slips_lane1", 64'(pulses[1]), 64'd8);
      src[1] = TRAIN;
      @(posedge c); #2;
      check("t5_err_sticky", 64'({align_err, aligned}), 64'b10);
      wait_aligned(200, "t5_aligned");
      check("t5_err_cleared", 64'(align_err), 64'd0);
      check("t5_slips_final", 64'(pulses[1]), 64'd8);

      // One-cycle lock drop while running.
      do_reset();
      wait_aligned(100, "t6_aligned");
      send(SYNC_FS, $urandom);
      send(SYNC_DV, $urandom);
      @(negedge c);
      rx_locked = 1'b0;
      for (int k = 0; k < 5; k++) src[k] = TRAIN;
      @(posedge c); #2;
      n_lat = 1;
      @(negedge c);
      rx_locked = 1'b1;
      for (int i = 2; i <= 6 && aligned; i++) begin
         @(posedge c); #2;
         n_lat = i;
      end
      check("t6_drop_latency", 64'(n_lat <= 3 && !aligned), 64'd1);
      check("t6_drop_px_valid", 64'(px_valid), 64'd0);
      wait_aligned(200, "t6_realigned");
      check("t6_realign_cnt", 64'(realign_cnt), STATS ? 64'd1 : 64'd0);

      // Reset asserted in the middle of a bitslip pulse.
      do_reset();
      skew[3] = 5;
      for (int i = 0; i < 200; i++) begin
         @(posedge c); #2;
         if (bitslip != 5'd0) break;
      end
      check("t7_in_slip", 64'(bitslip), 64'b01000);
      rst = 1'b1;
      #1;
      check_all_zero("t7_async");
      @(negedge c);
      @(negedge c);
      rst = 1'b0;
      wait_aligned(300, "t7_aligned");
      check("t7_no_err", 64'(align_err), 64'd0);

      repeat (3) @(negedge c);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
